v_demux_deserializer_8: RTL and testbench



---
 rtl/v_demux_pkg.sv | 13 +
 rtl/v_demux_slot_ctr.sv | 34 +++
 rtl/v_demux_deserializer_8.sv | 94 +++++++++
 tb/tb_v_demux_deserializer_8.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_demux_pkg.sv
// Shared slot mapping for the bit-select mux serializer and its demux deserializer.
// Both sides call slot_of() so sel N always means the same word bit on each end.
package v_demux_pkg;

   localparam int N_SLOTS_DEFAULT = 8;
   localparam int LANE_W_DEFAULT  = 1;

   // sel 0 addresses the most significant slot, matching the mux read order
   function automatic int slot_of(input int sel, input int n_slots = N_SLOTS_DEFAULT);
      return n_slots - 1 - sel;
   endfunction

endpackage

// File: rtl/v_demux_slot_ctr.sv
// Wrapping slot counter: enable steps 0..N_SLOTS-1, clr wins over en, tc flags the last slot.
// Single-cycle update; no backpressure of its own.
module v_demux_slot_ctr
   import v_demux_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEFAULT,
   localparam int SEL_W  = $clog2(N_SLOTS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [SEL_W-1:0] sel,
   output logic             tc
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SLOTS - 1);

   logic [SEL_W-1:0] sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= '0;
      end else if (clr) begin
         sel_q <= '0;
      end else if (en) begin
         sel_q <= (sel_q == LAST) ? '0 : sel_q + 1'b1;
      end
   end

   assign sel = sel_q;
   assign tc  = (sel_q == LAST);

endmodule

// File: rtl/v_demux_deserializer_8.sv
// 1-to-N_SLOTS lane deserializer; word valid the cycle after its last lane, one word per N_SLOTS cycles.
// Stalls only the final lane while the previous word is unconsumed; V_DEMUX_FLUSH_EN adds a partial-word flush.
module v_demux_deserializer_8
   import v_demux_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEFAULT,
   parameter int LANE_W  = LANE_W_DEFAULT,
   localparam int SEL_W  = $clog2(N_SLOTS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [LANE_W-1:0]         si,
   input  logic                      si_valid,
   output logic                      si_ready,
`ifdef V_DEMUX_FLUSH_EN
   input  logic                      flush,
`endif
   output logic [SEL_W-1:0]          sel_o,
   output logic [N_SLOTS*LANE_W-1:0] po,
   output logic                      po_valid,
   input  logic                      po_ready
);

   localparam int W = N_SLOTS * LANE_W;

   logic [SEL_W-1:0] sel;
   logic             tc;
   logic             accept;
   logic             complete;
   logic             flush_go;
   logic             stall;
   logic [W-1:0]     asm_q;
   logic [W-1:0]     merged;
   logic [W-1:0]     po_q;
   logic             po_valid_q;

   assign stall = tc && po_valid_q && !po_ready;

`ifdef V_DEMUX_FLUSH_EN
   // A flush waits for a free output; the requester keeps flush high until sel_o reads 0
   assign flush_go = flush && (sel != '0) && (!po_valid_q || po_ready);
   assign si_ready = !flush && !stall;
`else
   assign flush_go = 1'b0;
   assign si_ready = !stall;
`endif

   assign accept   = si_valid && si_ready;
   assign complete = accept && tc;

   always_comb begin
      merged = asm_q;
      merged[slot_of(int'(sel), N_SLOTS)*LANE_W +: LANE_W] = si;
   end

   v_demux_slot_ctr #(.N_SLOTS(N_SLOTS)) u_slot_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .clr   (flush_go),
      .sel   (sel),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q      <= '0;
         po_q       <= '0;
         po_valid_q <= 1'b0;
      end else begin
         if (complete || flush_go) begin
            asm_q <= '0;
         end else if (accept) begin
            asm_q <= merged;
         end

         // A completing word may replace one being consumed on the same edge
         if (complete) begin
            po_q       <= merged;
            po_valid_q <= 1'b1;
         end else if (flush_go) begin
            po_q       <= asm_q;
            po_valid_q <= 1'b1;
         end else if (po_valid_q && po_ready) begin
            po_valid_q <= 1'b0;
         end
      end
   end

   assign sel_o    = sel;
   assign po       = po_q;
   assign po_valid = po_valid_q;

endmodule

// File: tb/tb_v_demux_deserializer_8.sv
// Bench for v_demux_deserializer_8: directed scenarios plus a random stream against a queue-based word model.
module tb_v_demux_deserializer_8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       si = 1'b0;
   logic       si_valid = 1'b0;
   logic       si_ready;
   logic [2:0] sel_o;
   logic [7:0] po;
   logic       po_valid;
   logic       po_ready = 1'b0;
`ifdef V_DEMUX_FLUSH_EN
   logic       flush = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   v_demux_deserializer_8 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .si       (si),
      .si_valid (si_valid),
      .si_ready (si_ready),
`ifdef V_DEMUX_FLUSH_EN
      .flush    (flush),
`endif
      .sel_o    (sel_o),
      .po       (po),
      .po_valid (po_valid),
      .po_ready (po_ready)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      si_valid = 1'b0;
      si       = 1'b0;
      po_ready = 1'b0;
`ifdef V_DEMUX_FLUSH_EN
      flush    = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      do_reset;
      n_checks++; if (sel_o !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel_o); end
      n_checks++; if (po !== 8'h00) begin n_fail++; $display("FAIL reset_po: got %h want 00", po); end
      n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL reset_po_valid: got %b want 0", po_valid); end
      n_checks++; if (si_ready !== 1'b1) begin n_fail++; $display("FAIL reset_si_ready: got %b want 1", si_ready); end
   endtask

   task automatic test_basic;
      logic [7:0] w;
      w = 8'hB2;
      do_reset;
      po_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         si_valid = 1'b1;
         si = w[7-i];
         #1;
         n_checks++; if (sel_o !== 3'(i)) begin n_fail++; $display("FAIL basic_sel: got %0d want %0d", sel_o, i); end
         n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", po_valid); end
         tick;
      end
      si_valid = 1'b0;
      n_checks++; if (po_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", po_valid); end
      n_checks++; if (po !== 8'hB2) begin n_fail++; $display("FAIL basic_po: got %h want b2", po); end
      n_checks++; if (sel_o !== 3'd0) begin n_fail++; $display("FAIL basic_wrap: got %0d want 0", sel_o); end
      tick;
      n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b want 0", po_valid); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] s;
      logic        exp_v;
      logic [7:0]  exp_w;
      s = {8'hA5, 8'h3C};
      do_reset;
      po_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         si_valid = 1'b1;
         si = s[15-i];
         #1;
         n_checks++; if (si_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_si_ready: got %b want 1 at lane %0d", si_ready, i); end
         tick;
         exp_v = (i == 7) || (i == 15);
         exp_w = (i == 7) ? 8'hA5 : 8'h3C;
         n_checks++; if (po_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid: got %b want %b after lane %0d", po_valid, exp_v, i); end
         if (exp_v) begin
            n_checks++; if (po !== exp_w) begin n_fail++; $display("FAIL b2b_po: got %h want %h", po, exp_w); end
         end
      end
      si_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [7:0] w;
      w = 8'hFF;
      do_reset;
      po_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         si_valid = 1'b1; si = w[7-i]; tick;
      end
      n_checks++; if (po !== 8'hFF || po_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %h/%b want ff/1", po, po_valid); end
      w = 8'h01;
      for (int i = 0; i < 7; i++) begin
         si_valid = 1'b1; si = w[7-i];
         #1;
         n_checks++; if (si_ready !== 1'b1) begin n_fail++; $display("FAIL bp_lane_ready: got %b want 1 at lane %0d", si_ready, i); end
         tick;
      end
      si = w[0];
      #1;
      n_checks++; if (si_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b want 0", si_ready); end
      repeat (2) tick;
      n_checks++; if (po !== 8'hFF || po_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %h/%b want ff/1", po, po_valid); end
      n_checks++; if (sel_o !== 3'd7) begin n_fail++; $display("FAIL bp_sel_hold: got %0d want 7", sel_o); end
      po_ready = 1'b1;
      #1;
      n_checks++; if (si_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", si_ready); end
      tick;
      si_valid = 1'b0;
      n_checks++; if (po !== 8'h01 || po_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload: got %h/%b want 01/1", po, po_valid); end
      n_checks++; if (sel_o !== 3'd0) begin n_fail++; $display("FAIL bp_wrap: got %0d want 0", sel_o); end
      tick;
      n_checks++; if (po_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", po_valid); end
   endtask

   task automatic test_gaps;
      logic [7:0] w;
      logic [2:0] exp_sel;
      w = 8'h5A;
      do_reset;
      po_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         si_valid = 1'b1; si = w[7-i];
         tick;
         si_valid = 1'b0; si = ~si;
         exp_sel = 3'((i + 1) % 8);
         n_checks++; if (sel_o !== exp_sel) begin n_fail++; $display("FAIL gaps_sel: got %0d want %0d", sel_o, exp_sel); end
         if (i == 7) begin
            n_checks++; if (po !== 8'h5A || po_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_po: got %h/%b want 5a/1", po, po_valid); end
         end else begin
            repeat (2) tick;
            n_checks++; if (sel_o !== exp_sel) begin n_fail++; $display("FAIL gaps_hold: got %0d want %0d", sel_o, exp_sel); end
         end
      end
   endtask

   task automatic test_mid_reset;
      logic [7:0] w;
      do_reset;
      po_ready = 1'b0;
      w = 8'h77;
      for (int i = 0; i < 8; i++) begin
         si_valid = 1'b1; si = w[7-i]; tick;
      end
      for (int i = 0; i < 5; i++) begin
         si_valid = 1'b1; si = 1'b1; tick;
      end
      si_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      n_checks++; if (sel_o !== 3'd0 || po_valid !== 1'b0 || po !== 8'h00) begin n_fail++; $display("FAIL midrst_async: got sel %0d po %h v %b want 0/00/0", sel_o, po, po_valid); end
      tick;
      rst_n = 1'b1;
      tick;
      po_ready = 1'b1;
      w = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         si_valid = 1'b1; si = w[7-i]; tick;
      end
      si_valid = 1'b0;
      n_checks++; if (po !== 8'hC3 || po_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_word: got %h/%b want c3/1", po, po_valid); end
   endtask

   // Model: lanes collect MSB-first into a bit queue; a full queue becomes one output word
   task automatic test_random;
      logic       lanes[$];
      logic [7:0] words[$];
      logic [7:0] w;
      logic       exp_rdy;
      do_reset;
      for (int c = 0; c < 1200; c++) begin
         si_valid = ($urandom_range(0, 3) != 0);
         si       = 1'($urandom);
         po_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = !(lanes.size() == 7 && words.size() != 0 && !po_ready);
         n_checks++; if (si_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready: got %b want %b cycle %0d", si_ready, exp_rdy, c); end
         n_checks++; if (sel_o !== 3'(lanes.size())) begin n_fail++; $display("FAIL rnd_sel: got %0d want %0d cycle %0d", sel_o, lanes.size(), c); end
         n_checks++; if (po_valid !== (words.size() != 0)) begin n_fail++; $display("FAIL rnd_valid: got %b want %b cycle %0d", po_valid, words.size() != 0, c); end
         if (words.size() != 0) begin
            n_checks++; if (po !== words[0]) begin n_fail++; $display("FAIL rnd_po: got %h want %h cycle %0d", po, words[0], c); end
            if (po_ready) void'(words.pop_front());
         end
         if (si_valid && exp_rdy) begin
            lanes.push_back(si);
            if (lanes.size() == 8) begin
               w = 8'h00;
               foreach (lanes[k]) w = {w[6:0], lanes[k]};
               words.push_back(w);
               lanes.delete();
            end
         end
         tick;
      end
      si_valid = 1'b0;
   endtask

`ifdef V_DEMUX_FLUSH_EN
   task automatic test_flush;
      do_reset;
      po_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         si_valid = 1'b1; si = 1'b1; tick;
      end
      si_valid = 1'b1;
      flush = 1'b1;
      #1;
      n_checks++; if (si_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", si_ready); end
      tick;
      flush = 1'b0;
      si_valid = 1'b0;
      n_checks++; if (po !== 8'hE0 || po_valid !== 1'b1) begin n_fail++; $display("FAIL flush_po: got %h/%b want e0/1", po, po_valid); end
      n_checks++; if (sel_o !== 3'd0) begin n_fail++; $display("FAIL flush_sel: got %0d want 0", sel_o); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want finish before it");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_backpressure;
      test_gaps;
      test_mid_reset;
      test_random;
`ifdef V_DEMUX_FLUSH_EN
      test_flush;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
